fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences reads of the combinational instruction ROM. It drives a word-aligned byte address, captures the returned 32-bit instruction into a registered fetch/decode output with a valid/ready handshake, and accepts redirects (branches) from the execute stage. It detects misaligned or out-of-range fetches and enters a sticky fault state instead of issuing bad addresses.

## Interface
- `MEM_SIZE`, 1024: ROM size in bytes; power of two, > 4.
- `RESET_PC`, 0: first fetch address after reset; must be word-aligned.

- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `address` out 64: byte address to the instruction ROM; always equals `pc`.
- `instruction` in 32: ROM read data, valid in the same cycle as `address`.
- `out_valid` out 1: `out_instr`/`out_pc` hold a fetched instruction.
- `out_ready` in 1: decoder accepts the output this cycle.
- `out_instr` out 32: registered instruction.
- `out_pc` out 64: address `out_instr` was fetched from.
- `redirect_valid` in 1: load a new PC (taken branch); flushes the output.
- `redirect_pc` in 64: redirect target.
- `fault` out 1: sticky fetch fault.
- `fetch_count` out 32: number of instructions handed to the decoder (handshakes), wraps at 2^32.

## Operation
- States: IDLE, FETCH, FAULT.
- Reset: `pc`=RESET_PC, state IDLE, `out_valid`=0, `out_instr`=0, `out_pc`=0, `fault`=0, `fetch_count`=0.
- IDLE: one bubble cycle, then FETCH. Redirects in IDLE are applied: `pc`<=`redirect_pc`.
- FETCH, per cycle, in priority order:
  1. Redirect. If `redirect_valid`, `pc`<=`redirect_pc` and `out_valid`<=0. Any output present is discarded; a same-cycle handshake still counts. No load occurs. If `redirect_pc[1:0]`!=0, go to FAULT.
  2. Slot free. The slot is free when `out_valid`==0, or `out_valid`&&`out_ready`. If `pc` is legal: `out_instr`<=`instruction`, `out_pc`<=`pc`, `out_valid`<=1, `pc`<=`pc`+4.
  3. Slot occupied and not accepted. Hold `pc`, `out_*` and `out_valid` unchanged.
- Legal `pc`: `pc[1:0]`==0; with `FETCH_BOUNDS_CHECK_EN`, also `pc`+3 < MEM_SIZE. Attempting to load from an illegal `pc` → FAULT with no load.
- FAULT: `fault`=1, `out_valid`<=0, `pc` frozen, redirects ignored. Only `reset` exits.
- `fetch_count` increments on every cycle with `out_valid`&&`out_ready`, in any state.
- `pc` arithmetic is 64-bit unsigned and wraps at 2^64.

## Timing
- Fetch latency: an instruction at address A appears on `out_instr` the cycle after `pc`==A.
- Steady state with `out_ready`=1: one instruction per cycle.
- First valid output: cycle 2 after `reset` deasserts (IDLE, FETCH, valid).
- Redirect cost: one bubble. `out_valid`=0 in the cycle after the redirect; the target instruction is valid the cycle after that.
- `fault` asserts the cycle after the illegal attempt. `out_valid` drops in that same cycle.
- `reset` asserted mid-operation overrides everything on the next edge.

## Configuration
- `FETCH_BOUNDS_CHECK_EN` defined: a fetch at `pc`+3 >= MEM_SIZE faults.
- Not defined: only alignment is checked. Out-of-range addresses are issued and the ROM data (possibly X) is loaded as-is.

## Test plan
- Sequential fetch: reset with RESET_PC=0, `out_ready`=1, ROM words 0..3 = 0xA0..0xA3 → `out_pc` 0,4,8,12 on consecutive cycles from cycle 2; `fetch_count`=4.
- Backpressure: `out_ready`=0 for 3 cycles while `out_pc`=4 → output and `pc`=8 held; release → `out_pc`=8 next cycle with no skipped word.
- Redirect: `redirect_valid`=1, `redirect_pc`=0x40, with `out_pc`=8 valid and `out_ready`=0 → next cycle `out_valid`=0, then `out_pc`=0x40; `fetch_count` unchanged.
- Misaligned redirect: `redirect_pc`=0x42 → `fault`=1 next cycle, `out_valid`=0, `address` stuck at 0x42; a later redirect is ignored; `reset` clears the fault.
- Bounds: with the macro defined and `pc` running to 1020 → 1020 fetched, then `fault`=1 at `pc`=1024. Without the macro, `out_pc`=1024 is issued and no fault occurs.
- Reset mid-stream: `reset` while `out_valid`=1 → next cycle all outputs at reset values, `pc`=RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Owns the PC and drives instruction-ROM fetches into a one-entry
//             valid/ready output slot. It accepts redirects and faults on
//             illegal fetch addresses.
//  Options  : FETCH_BOUNDS_CHECK_EN  - also fault when pc+3 >= MEM_SIZE
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] address,
    input  logic [31:0] instruction,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        handshake;
    logic        slot_free;
    logic        in_bounds;
    logic        pc_legal;

    assign handshake = out_valid_q && out_ready;
    assign slot_free = !out_valid_q || out_ready;

`ifdef FETCH_BOUNDS_CHECK_EN
    // 65-bit sum so a PC near 2^64 cannot wrap back into range
    assign in_bounds = (({1'b0, pc_q} + 65'd3) < 65'(MEM_SIZE));
`else
    assign in_bounds = 1'b1;
`endif

    assign pc_legal = (pc_q[1:0] == 2'b00) && in_bounds;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        fetch_count_d = handshake ? fetch_count_q + 32'd1 : fetch_count_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_d        = redirect_pc;
                    out_valid_d = 1'b0;
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_d = S_FAULT;
                    end
                end else if (slot_free) begin
                    if (pc_legal) begin
                        out_instr_d = instruction;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + 64'd4;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = S_FAULT;
                    end
                end
            end
            S_FAULT: begin
                out_valid_d = 1'b0;
            end
            default: begin
                state_d     = S_FAULT;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_instr_q   <= 32'd0;
            out_pc_q      <= 64'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign address     = pc_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign fault       = (state_q == S_FAULT);
    assign fetch_count = fetch_count_q;

endmodule

`default_nettype wire
